// File: rtl/sobel_window_ctrl.sv
// Raster-order pixel sequencer for sobel_calc: two line buffers plus a 3x3 shift window,
// emitting one registered window strobe per interior pixel and a pulse on the frame's last window.
module sobel_window_ctrl #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             pix_valid_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] d0_o,
  output logic [PIX_W-1:0] d1_o,
  output logic [PIX_W-1:0] d2_o,
  output logic [PIX_W-1:0] d3_o,
  output logic [PIX_W-1:0] d4_o,
  output logic [PIX_W-1:0] d5_o,
  output logic [PIX_W-1:0] d6_o,
  output logic [PIX_W-1:0] d7_o,
  output logic [PIX_W-1:0] d8_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [PIX_W-1:0] r_lb0 [IMG_W];
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] r_win [9];
  logic             r_done;
  logic             r_frameDone;

  logic             w_accept;
  logic             w_lastPix;
  logic             w_interior;
  logic [PIX_W-1:0] w_tap0;
  logic [PIX_W-1:0] w_tap1;

  assign w_accept   = pix_valid_i && (r_state == S_LOAD);
  assign w_lastPix  = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_interior = (r_row >= ROW_TWO) && (r_col >= COL_TWO);
  assign w_tap0     = r_lb0[r_col];
  assign w_tap1     = r_lb1[r_col];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_nextState = S_LOAD;
      S_LOAD:  if (w_accept && w_lastPix) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // The last pixel clears both counters, so the frame leaves LOAD already positioned at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_lastPix) begin
        r_col <= '0;
        r_row <= '0;
      end else if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffers carry no reset so they map onto RAM; rows 0 and 1 overwrite them before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= pix_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else if (w_accept) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_tap0;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_tap1;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= pix_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_done      <= w_accept && w_interior;
      r_frameDone <= w_accept && w_lastPix;
    end
  end

  assign d0_o         = r_win[0];
  assign d1_o         = r_win[1];
  assign d2_o         = r_win[2];
  assign d3_o         = r_win[3];
  assign d4_o         = r_win[4];
  assign d5_o         = r_win[5];
  assign d6_o         = r_win[6];
  assign d7_o         = r_win[7];
  assign d8_o         = r_win[8];
  assign done_o       = r_done;
  assign frame_done_o = r_frameDone;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 5x4 frame where pixel(r,c) = 5r+c+1 (+ offset).
// Windows are captured on the falling edge and compared against a hand-computed table.
module tb_sobel_window_ctrl;

  localparam int PIX_W = 8;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);

  typedef struct {
    int d[9];
    bit fd;
  } winVec_t;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic             pix_valid_i;
  logic [PIX_W-1:0] pix_i;
  logic [PIX_W-1:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
  logic             done_o;
  logic             busy_o;
  logic             frame_done_o;

  int      checks;
  int      errors;
  winVec_t vecs [NWIN];
  winVec_t winQ [$];
  logic    lastValid;

  sobel_window_ctrl #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pix_valid_i  (pix_valid_i),
    .pix_i        (pix_i),
    .d0_o         (d0_o),
    .d1_o         (d1_o),
    .d2_o         (d2_o),
    .d3_o         (d3_o),
    .d4_o         (d4_o),
    .d5_o         (d5_o),
    .d6_o         (d6_o),
    .d7_o         (d7_o),
    .d8_o         (d8_o),
    .done_o       (done_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) lastValid <= pix_valid_i;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // A strobe is only legal in the cycle after an accepted pixel.
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      winVec_t w;
      w.d[0] = int'(d0_o); w.d[1] = int'(d1_o); w.d[2] = int'(d2_o);
      w.d[3] = int'(d3_o); w.d[4] = int'(d4_o); w.d[5] = int'(d5_o);
      w.d[6] = int'(d6_o); w.d[7] = int'(d7_o); w.d[8] = int'(d8_o);
      w.fd   = frame_done_o;
      winQ.push_back(w);
      checkOutput("strobe after valid", int'(lastValid), 1);
    end else if (frame_done_o === 1'b1) begin
      checkOutput("frame_done without done", 0, 1);
    end
  end

  task automatic applyStimulus(input bit v, input int p);
    pix_valid_i = v;
    pix_i       = PIX_W'(p);
    @(posedge clk);
    #1;
  endtask

  task automatic startFrame();
    start_i = 1'b1;
    applyStimulus(0, 0);
    start_i = 1'b0;
  endtask

  // flat >= 0 sends a constant frame, otherwise the ramp pattern plus offset.
  task automatic sendPixels(input int offset, input bit gaps, input int flat, input int count);
    for (int k = 0; k < count; k++) begin
      if (gaps) applyStimulus(0, 8'hAA);
      applyStimulus(1, (flat >= 0) ? flat : (k + 1 + offset));
    end
    pix_valid_i = 1'b0;
  endtask

  function automatic int sobelMag(input winVec_t w);
    int gx, gy;
    gx = (w.d[2] + 2 * w.d[5] + w.d[8]) - (w.d[0] + 2 * w.d[3] + w.d[6]);
    gy = (w.d[6] + 2 * w.d[7] + w.d[8]) - (w.d[0] + 2 * w.d[1] + w.d[2]);
    return ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
  endfunction

  task automatic checkFrame(input string tag, input int offset, input int flat);
    winVec_t w;
    for (int i = 0; i < NWIN; i++) begin
      if (winQ.size() == 0) begin
        checkOutput($sformatf("%s missing window %0d", tag, i), 0, 1);
        return;
      end
      w = winQ.pop_front();
      for (int j = 0; j < 9; j++)
        checkOutput($sformatf("%s win%0d d%0d", tag, i, j), w.d[j],
                    (flat >= 0) ? flat : vecs[i].d[j] + offset);
      checkOutput($sformatf("%s win%0d frame_done", tag, i), int'(w.fd), int'(vecs[i].fd));
      if (flat >= 0) checkOutput($sformatf("%s win%0d gradient", tag, i), sobelMag(w), 0);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " busy_o"}, int'(busy_o), 0);
    checkOutput({tag, " done_o"}, int'(done_o), 0);
    checkOutput({tag, " frame_done_o"}, int'(frame_done_o), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0].d = '{1, 2, 3, 6, 7, 8, 11, 12, 13};      vecs[0].fd = 1'b0;
    vecs[1].d = '{2, 3, 4, 7, 8, 9, 12, 13, 14};      vecs[1].fd = 1'b0;
    vecs[2].d = '{3, 4, 5, 8, 9, 10, 13, 14, 15};     vecs[2].fd = 1'b0;
    vecs[3].d = '{6, 7, 8, 11, 12, 13, 16, 17, 18};   vecs[3].fd = 1'b0;
    vecs[4].d = '{7, 8, 9, 12, 13, 14, 17, 18, 19};   vecs[4].fd = 1'b0;
    vecs[5].d = '{8, 9, 10, 13, 14, 15, 18, 19, 20};  vecs[5].fd = 1'b1;

    rst = 1'b1; start_i = 1'b0; pix_valid_i = 1'b0; pix_i = '0;
    #12;
    checkIdleOutputs("reset");
    checkOutput("reset d0_o", int'(d0_o), 0);
    checkOutput("reset d8_o", int'(d8_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 0);

    // Frame 1: junk before start, then back-to-back pixels, then junk during DONE.
    for (int k = 0; k < 3; k++) applyStimulus(1, 77);
    checkIdleOutputs("pre-start");
    startFrame();
    checkOutput("f1 busy after start", int'(busy_o), 1);
    sendPixels(0, 0, -1, IMG_W * IMG_H);
    checkOutput("f1 busy in DONE", int'(busy_o), 1);
    checkOutput("f1 frame_done_o", int'(frame_done_o), 1);
    applyStimulus(1, 99);
    applyStimulus(1, 98);
    pix_valid_i = 1'b0;
    checkIdleOutputs("f1 after DONE");
    checkOutput("f1 strobes", winQ.size(), NWIN);
    checkFrame("f1", 0, -1);

    // Frame 2: gap before every pixel, start_i held high mid-frame has no effect.
    startFrame();
    start_i = 1'b1;
    sendPixels(0, 1, -1, IMG_W * IMG_H);
    start_i = 1'b0;
    checkOutput("f2 busy in DONE", int'(busy_o), 1);
    applyStimulus(0, 0);
    checkIdleOutputs("f2 after DONE");
    checkOutput("f2 strobes", winQ.size(), NWIN);
    checkFrame("f2", 0, -1);

    // Frames 3/4 back-to-back with different data.
    startFrame();
    sendPixels(0, 0, -1, IMG_W * IMG_H);
    applyStimulus(0, 0);
    startFrame();
    sendPixels(100, 0, -1, IMG_W * IMG_H);
    applyStimulus(0, 0);
    checkOutput("f3f4 strobes", winQ.size(), 2 * NWIN);
    checkFrame("f3", 0, -1);
    checkFrame("f4", 100, -1);

    // Reset after 12 pixels: everything cleared at once, no windows produced.
    startFrame();
    sendPixels(0, 0, -1, 12);
    rst = 1'b1;
    #1;
    checkIdleOutputs("mid reset");
    checkOutput("mid reset d8_o", int'(d8_o), 0);
    checkOutput("mid reset d4_o", int'(d4_o), 0);
    checkOutput("mid reset strobes", winQ.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 0);
    startFrame();
    sendPixels(0, 0, -1, IMG_W * IMG_H);
    applyStimulus(0, 0);
    checkOutput("f5 strobes", winQ.size(), NWIN);
    checkFrame("f5", 0, -1);

    // Flat frame: every window uniform, zero Sobel gradient.
    startFrame();
    sendPixels(0, 0, 50, IMG_W * IMG_H);
    applyStimulus(0, 0);
    checkOutput("flat strobes", winQ.size(), NWIN);
    checkFrame("flat", 0, 50);

    repeat (3) applyStimulus(0, 0);
    checkOutput("no stray strobes", winQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
